// File: rtl/packet_classifier_pkg.sv
// rtl/packet_classifier_pkg.sv - shared widths, class codes, FSM states and flow table entry layout
package packet_classifier_pkg;

  localparam int FLOW_ID_WIDTH_DEF    = 16;
  localparam int PKT_LENGTH_WIDTH_DEF = 11;
  localparam int FLOW_CLASS_WIDTH_DEF = 2;
  localparam int TABLE_ADDR_WIDTH_DEF = 10;
  localparam int PKTS_TO_CLASSIFY_DEF = 4;
  localparam int TH_SMALL_DEF         = 128;
  localparam int TH_LARGE_DEF         = 1024;

  // count must be able to hold N itself, sum must hold N maximum-length packets
  localparam int CNT_WIDTH = $clog2(PKTS_TO_CLASSIFY_DEF) + 1;
  localparam int SUM_WIDTH = PKT_LENGTH_WIDTH_DEF + $clog2(PKTS_TO_CLASSIFY_DEF);

  typedef enum logic [FLOW_CLASS_WIDTH_DEF-1:0] {
    CLASS_UNKNOWN = 2'd0,
    CLASS_SMALL   = 2'd1,
    CLASS_MEDIUM  = 2'd2,
    CLASS_LARGE   = 2'd3
  } flow_class_e;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_READ   = 2'd2,
    ST_UPDATE = 2'd3
  } state_e;

  typedef struct packed {
    logic                            valid;
    logic [FLOW_ID_WIDTH_DEF-1:0]    tag;
    logic [CNT_WIDTH-1:0]            count;
    logic [SUM_WIDTH-1:0]            sum;
    logic [FLOW_CLASS_WIDTH_DEF-1:0] flow_class;
  } flow_entry_t;

endpackage

// File: rtl/packet_classifier_flow_table_ram.sv
// rtl/packet_classifier_flow_table_ram.sv - single-port synchronous-read flow table RAM
module flow_table_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 35
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // No reset on the array or read register so the tools map this onto block RAM;
  // rdata holds its value on cycles without a read
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/packet_classifier.sv
// rtl/packet_classifier.sv - per-flow packet length classifier with on-chip flow table
module packet_classifier
  import packet_classifier_pkg::*;
#(
  parameter int FLOW_ID_WIDTH    = FLOW_ID_WIDTH_DEF,
  parameter int PKT_LENGTH_WIDTH = PKT_LENGTH_WIDTH_DEF,
  parameter int FLOW_CLASS_WIDTH = FLOW_CLASS_WIDTH_DEF,
  parameter int TABLE_ADDR_WIDTH = TABLE_ADDR_WIDTH_DEF,
  parameter int PKTS_TO_CLASSIFY = PKTS_TO_CLASSIFY_DEF,
  parameter int TH_SMALL         = TH_SMALL_DEF,
  parameter int TH_LARGE         = TH_LARGE_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [FLOW_ID_WIDTH-1:0]    in_flow_id,
  input  logic [PKT_LENGTH_WIDTH-1:0] in_length,
  input  logic                        in_wr,
  output logic                        in_ready,
  output logic [FLOW_CLASS_WIDTH-1:0] out_flow_class,
  output logic                        out_wr
);

  localparam int LOG2_N      = $clog2(PKTS_TO_CLASSIFY);
  localparam int TABLE_DEPTH = 1 << TABLE_ADDR_WIDTH;
  localparam int ENTRY_WIDTH = $bits(flow_entry_t);

  localparam logic [TABLE_ADDR_WIDTH-1:0] LAST_ADDR  = TABLE_ADDR_WIDTH'(TABLE_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]        N_CNT      = CNT_WIDTH'(PKTS_TO_CLASSIFY);
  localparam logic [PKT_LENGTH_WIDTH-1:0] TH_SMALL_L = PKT_LENGTH_WIDTH'(TH_SMALL);
  localparam logic [PKT_LENGTH_WIDTH-1:0] TH_LARGE_L = PKT_LENGTH_WIDTH'(TH_LARGE);

  state_e                        state_q, state_d;
  logic [TABLE_ADDR_WIDTH-1:0]   init_addr_q, init_addr_d;
  logic                          in_ready_q, in_ready_d;
  logic                          out_wr_q, out_wr_d;
  logic [FLOW_CLASS_WIDTH-1:0]   out_class_q, out_class_d;
  logic [FLOW_ID_WIDTH-1:0]      id_q, id_d;
  logic [PKT_LENGTH_WIDTH-1:0]   len_q, len_d;

  logic                          ram_en;
  logic                          ram_we;
  logic [TABLE_ADDR_WIDTH-1:0]   ram_addr;
  flow_entry_t                   ram_wdata;
  flow_entry_t                   ram_rdata;

  logic                          hit;
  logic [CNT_WIDTH-1:0]          cnt_inc;
  logic [SUM_WIDTH-1:0]          sum_inc;
  logic [PKT_LENGTH_WIDTH-1:0]   avg;
  logic [FLOW_CLASS_WIDTH-1:0]   class_calc;

  flow_table_ram #(
    .ADDR_WIDTH (TABLE_ADDR_WIDTH),
    .DATA_WIDTH (ENTRY_WIDTH)
  ) u_flow_table_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Lookup result and the statistics the entry would hold after this packet
  always_comb begin
    hit     = ram_rdata.valid && (ram_rdata.tag == id_q);
    cnt_inc = ram_rdata.count + 1'b1;
    sum_inc = ram_rdata.sum + SUM_WIDTH'(len_q);
    avg     = PKT_LENGTH_WIDTH'(sum_inc >> LOG2_N);
    if (avg < TH_SMALL_L) begin
      class_calc = CLASS_SMALL;
    end else if (avg >= TH_LARGE_L) begin
      class_calc = CLASS_LARGE;
    end else begin
      class_calc = CLASS_MEDIUM;
    end
  end

  // Next-state, RAM port and output decode for the init / idle / read / update sequence
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    in_ready_d  = in_ready_q;
    out_wr_d    = 1'b0;
    out_class_d = out_class_q;
    id_d        = id_q;
    len_d       = len_q;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = init_addr_q;
    ram_wdata   = '0;

    case (state_q)
      ST_INIT: begin
        ram_en      = 1'b1;
        ram_we      = 1'b1;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == LAST_ADDR) begin
          state_d     = ST_IDLE;
          in_ready_d  = 1'b1;
          init_addr_d = '0;
        end
      end
      ST_IDLE: begin
        if (in_wr && in_ready_q) begin
          ram_en     = 1'b1;
          ram_addr   = in_flow_id[TABLE_ADDR_WIDTH-1:0];
          id_d       = in_flow_id;
          len_d      = in_length;
          in_ready_d = 1'b0;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        ram_addr   = id_q[TABLE_ADDR_WIDTH-1:0];
        out_wr_d   = 1'b1;
        in_ready_d = 1'b1;
        state_d    = ST_IDLE;
        if (!hit) begin
          // new flow or eviction of whatever occupied this slot
          ram_en               = 1'b1;
          ram_we               = 1'b1;
          ram_wdata.valid      = 1'b1;
          ram_wdata.tag        = id_q;
          ram_wdata.count      = CNT_WIDTH'(1);
          ram_wdata.sum        = SUM_WIDTH'(len_q);
          ram_wdata.flow_class = CLASS_UNKNOWN;
          out_class_d          = CLASS_UNKNOWN;
        end else if (ram_rdata.flow_class != CLASS_UNKNOWN) begin
          out_class_d = ram_rdata.flow_class;
        end else begin
          ram_en               = 1'b1;
          ram_we               = 1'b1;
          ram_wdata            = ram_rdata;
          ram_wdata.count      = cnt_inc;
          ram_wdata.sum        = sum_inc;
          ram_wdata.flow_class = (cnt_inc == N_CNT) ? class_calc : CLASS_UNKNOWN;
          out_class_d          = (cnt_inc == N_CNT) ? class_calc : CLASS_UNKNOWN;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Control state and registered outputs; reset abandons any in-flight update and restarts the table clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      in_ready_q  <= 1'b0;
      out_wr_q    <= 1'b0;
      out_class_q <= '0;
      id_q        <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      in_ready_q  <= in_ready_d;
      out_wr_q    <= out_wr_d;
      out_class_q <= out_class_d;
      id_q        <= id_d;
      len_q       <= len_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_wr         = out_wr_q;
  assign out_flow_class = out_class_q;

endmodule

// File: tb/tb_packet_classifier.sv
// tb/tb_packet_classifier.sv - scoreboard bench for packet_classifier
module tb_packet_classifier;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_flow_id = '0;
  logic [10:0] in_length = '0;
  logic        in_wr = 1'b0;
  logic        in_ready;
  logic [1:0]  out_flow_class;
  logic        out_wr;

  packet_classifier dut (
    .clk            (clk),
    .reset          (reset),
    .in_flow_id     (in_flow_id),
    .in_length      (in_length),
    .in_wr          (in_wr),
    .in_ready       (in_ready),
    .out_flow_class (out_flow_class),
    .out_wr         (out_wr)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int n_acc  = 0;
  int n_out  = 0;
  int last_out_cyc = 0;
  int prev_out_cyc = 0;
  int last_cls = 0;

  int exp_q[$];
  int acc_q[$];

  bit m_valid [1024];
  int m_tag   [1024];
  int m_cnt   [1024];
  int m_sum   [1024];
  int m_cls   [1024];

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
  endfunction

  // Reference behaviour of one packet against the bench's own copy of the table
  function automatic int model_pkt(input int id, input int len);
    int idx;
    int avg;
    idx = id % 1024;
    if (!m_valid[idx] || m_tag[idx] != id) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = id;
      m_cnt[idx]   = 1;
      m_sum[idx]   = len;
      m_cls[idx]   = 0;
      return 0;
    end
    if (m_cls[idx] != 0) return m_cls[idx];
    m_cnt[idx] = m_cnt[idx] + 1;
    m_sum[idx] = m_sum[idx] + len;
    if (m_cnt[idx] == 4) begin
      avg = m_sum[idx] / 4;
      if (avg < 128)       m_cls[idx] = 1;
      else if (avg >= 1024) m_cls[idx] = 3;
      else                  m_cls[idx] = 2;
      return m_cls[idx];
    end
    return 0;
  endfunction

  // Accept tracking at the active edge (pre-edge values of in_wr/in_ready)
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset && in_wr && in_ready) begin
      acc_q.push_back(cyc);
      n_acc++;
    end
  end

  // Output monitor: pop the scoreboard and check class and latency
  always @(negedge clk) begin
    if (reset && out_wr) begin
      n_out++;
      prev_out_cyc = last_out_cyc;
      last_out_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("spurious_out_wr", 1, 0);
      end else begin
        last_cls = exp_q.pop_front();
        check("out_flow_class", int'(out_flow_class), last_cls);
        if (acc_q.size() != 0) check("out_latency", cyc - acc_q.pop_front(), 2);
        else check("accept_record", 0, 1);
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic send(input int id, input int len);
    wait_ready();
    in_flow_id = 16'(id);
    in_length  = 11'(len);
    in_wr      = 1'b1;
    exp_q.push_back(model_pkt(id, len));
    @(negedge clk);
    in_wr = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic release_and_init(input string tag);
    int cnt = 0;
    bit saw_out = 1'b0;
    reset = 1'b1;
    while (!in_ready && cnt < 1100) begin
      @(negedge clk);
      cnt++;
      if (out_wr) saw_out = 1'b1;
    end
    check({tag, "_init_cycles"}, cnt, 1024);
    check({tag, "_init_out_wr"}, int'(saw_out), 0);
  endtask

  initial begin
    int acc0;
    int out0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_out_wr", int'(out_wr), 0);
    check("reset_out_class", int'(out_flow_class), 0);
    release_and_init("por");

    for (int i = 0; i < 5; i++) send(5, 100);
    drain();
    check("hold_class", int'(out_flow_class), last_cls);

    for (int i = 0; i < 4; i++) send(7, 1024);
    for (int i = 0; i < 4; i++) send(8, 128);
    send(9, 127); send(9, 127); send(9, 127); send(9, 128);
    for (int i = 0; i < 4; i++) send(50, 0);
    for (int i = 0; i < 4; i++) send(60, 2047);
    drain();

    send(3, 500); send(3, 500);
    send(1027, 500);
    for (int i = 0; i < 4; i++) send(3, 50);
    drain();

    wait_ready();
    acc0 = n_acc;
    out0 = n_out;
    in_flow_id = 16'd40;
    in_length  = 11'd500;
    in_wr      = 1'b1;
    exp_q.push_back(model_pkt(40, 500));
    exp_q.push_back(model_pkt(40, 500));
    repeat (6) @(negedge clk);
    in_wr = 1'b0;
    drain();
    check("held_accepts", n_acc - acc0, 2);
    check("held_out_pulses", n_out - out0, 2);
    check("held_pulse_spacing", last_out_cyc - prev_out_cyc, 3);

    for (int i = 0; i < 3; i++) send(20, 900);
    drain();
    wait_ready();
    out0 = n_out;
    in_flow_id = 16'd20;
    in_length  = 11'd900;
    in_wr      = 1'b1;
    @(negedge clk);
    in_wr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_in_ready", int'(in_ready), 0);
    check("abort_out_wr", int'(out_wr), 0);
    repeat (3) @(negedge clk);
    check("abort_no_pulse", n_out - out0, 0);
    acc_q.delete();
    model_reset();
    release_and_init("rerun");
    send(20, 900);
    drain();

    for (int i = 0; i < 24; i++) begin
      int pick;
      pick = $urandom_range(0, 2);
      send((pick == 0) ? 100 : (pick == 1) ? 101 : 1124, $urandom_range(0, 2047));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
